// File: rtl/gpio_pwm_timer_pkg.sv
// Shared GPIO header: default bus widths for the PWM timer slice.
// The selector width is derived from the prescaler bus width.
package gpio_pwm_timer_pkg;

    localparam int GPIO_PRESCALER = 16;
    localparam int GPIO_WIDTH     = 16;

    // Width of an index into an n-bit bus, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GPIO_SELW = sel_width(GPIO_PRESCALER);

endpackage

// File: rtl/gpio_tick_gen.sv
// Turns the rising edge of one selected prescaler bit into a single-cycle tick.
// A change of selection suppresses the tick for that cycle to avoid a false edge.
module gpio_tick_gen
    import gpio_pwm_timer_pkg::*;
#(
    parameter int PRESCALER = GPIO_PRESCALER,
    parameter int SELW      = sel_width(PRESCALER)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PRESCALER-1:0] core_clk,
    input  logic [SELW-1:0]      prescaler_sel,
    output logic                 tick
);

    logic            tap;
    logic            tap_q;
    logic [SELW-1:0] sel_q;

    assign tap  = core_clk[prescaler_sel];
    assign tick = tap & ~tap_q & (prescaler_sel == sel_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_q <= 1'b0;
            sel_q <= '0;
        end else begin
            tap_q <= tap;
            sel_q <= prescaler_sel;
        end
    end

endmodule

// File: rtl/gpio_pwm_timer.sv
// Tick-driven PWM timer with double-buffered period/duty that switch over
// only at a period boundary, or immediately while the timer is disabled.
module gpio_pwm_timer
    import gpio_pwm_timer_pkg::*;
#(
    parameter int PRESCALER = GPIO_PRESCALER,
    parameter int WIDTH     = GPIO_WIDTH,
    parameter int SELW      = sel_width(PRESCALER)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PRESCALER-1:0] core_clk,
    input  logic [SELW-1:0]      prescaler_sel,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     period_in,
    input  logic [WIDTH-1:0]     duty_in,
    input  logic                 load,
    output logic                 load_pending,
    output logic                 pwm_out,
    output logic                 period_tick,
    output logic [WIDTH-1:0]     count
);

    logic             tick;
    logic [WIDTH-1:0] period_act, duty_act, period_pnd, duty_pnd;
    logic [WIDTH-1:0] period_act_next, duty_act_next, period_pnd_next, duty_pnd_next;
    logic [WIDTH-1:0] count_next;
    logic             load_pending_next, period_tick_next, pwm_next, apply;

    gpio_tick_gen #(
        .PRESCALER(PRESCALER),
        .SELW     (SELW)
    ) u_tick_gen (
        .clk          (clk),
        .rst          (rst),
        .core_clk     (core_clk),
        .prescaler_sel(prescaler_sel),
        .tick         (tick)
    );

    always_comb begin
        count_next        = count;
        period_tick_next  = 1'b0;
        apply             = 1'b0;
        period_act_next   = period_act;
        duty_act_next     = duty_act;
        period_pnd_next   = period_pnd;
        duty_pnd_next     = duty_pnd;
        load_pending_next = load_pending;

        if (!enable) begin
            count_next = '0;
            apply      = load_pending;
        end else if (tick) begin
            if (count == period_act) begin
                count_next       = '0;
                period_tick_next = 1'b1;
                apply            = load_pending;
            end else begin
                count_next = count + WIDTH'(1);
            end
        end

        if (apply) begin
            period_act_next   = period_pnd;
            duty_act_next     = duty_pnd;
            load_pending_next = 1'b0;
        end

        // A load on the applying edge refills pending after the old contents moved over.
        if (load) begin
            period_pnd_next   = period_in;
            duty_pnd_next     = duty_in;
            load_pending_next = 1'b1;
        end

        pwm_next = enable & (count_next < duty_act_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            pwm_out      <= 1'b0;
            period_tick  <= 1'b0;
            load_pending <= 1'b0;
            period_act   <= '0;
            duty_act     <= '0;
            period_pnd   <= '0;
            duty_pnd     <= '0;
        end else begin
            count        <= count_next;
            pwm_out      <= pwm_next;
            period_tick  <= period_tick_next;
            load_pending <= load_pending_next;
            period_act   <= period_act_next;
            duty_act     <= duty_act_next;
            period_pnd   <= period_pnd_next;
            duty_pnd     <= duty_pnd_next;
        end
    end

endmodule

// File: doc/gpio_pwm_timer.md
# gpio_pwm_timer

Tick-driven PWM timer consuming the free-running prescaler counter bus in the GPIO block. Selects one prescaler bit as a timebase, converts its rising edge into a one-cycle tick, and runs a period/duty counter. Period and duty are double-buffered so software updates take effect only at a period boundary. Sits directly downstream of the prescaler counter; drives a GPIO pin mux input and a per-period event to the GPIO interrupt logic.

## Interface
- PRESCALER, 16, width of the incoming prescaler counter bus
- WIDTH, 16, width of the period, duty and count registers
- SELW, 4, width of prescaler_sel; equals clog2(PRESCALER)

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- core_clk  in  PRESCALER  free-running prescaler counter, synchronous to clk
- prescaler_sel  in  SELW  index of the core_clk bit used as timebase
- enable  in  1  timer run enable (level)
- period_in  in  WIDTH  new period value; period length = period+1 ticks
- duty_in  in  WIDTH  new duty value; pwm_out high while count < duty
- load  in  1  one-cycle strobe capturing period_in/duty_in into pending registers
- load_pending  out  1  pending values not yet applied
- pwm_out  out  1  PWM waveform
- period_tick  out  1  one-cycle pulse at each period wrap
- count  out  WIDTH  current tick count

## Operation
- Tap = core_clk[prescaler_sel]. Registers tap_q and sel_q. tick = tap & ~tap_q & (prescaler_sel == sel_q). Selecting bit k gives one tick every 2^(k+1) clk cycles.
- A cycle in which prescaler_sel differs from sel_q produces no tick; tap_q and sel_q reload normally.
- Active registers period_act, duty_act; pending registers period_pnd, duty_pnd.
- load=1: pending <= inputs, load_pending <= 1. A load while already pending overwrites pending; load_pending stays 1.
- enable=1 and tick: if count == period_act, count <= 0, period_tick <= 1, and if load_pending (value before this edge) then active <= pending, load_pending <= 0; else count <= count+1.
- load in the same cycle as a wrap: wrap applies the previous pending contents (if any); the new values go to pending and load_pending ends at 1.
- enable=0: count <= 0, pwm_out <= 0, period_tick <= 0; if load_pending, active <= pending and load_pending <= 0 on the next edge.
- pwm_out <= enable & (count_next < duty_act_next). duty=0 gives constant low; duty > period gives constant high.
- period_act=0: every tick is a wrap; period_tick pulses on every tick.
- Count arithmetic is unsigned WIDTH bits. count never exceeds period_act, so it cannot wrap past 2^WIDTH-1.

## Timing
- Reset values: count=0, pwm_out=0, period_tick=0, load_pending=0, period_act=0, duty_act=0, period_pnd=0, duty_pnd=0, tap_q=0, sel_q=0.
- Tick is combinational in the cycle in which core_clk shows the tap rising. count, pwm_out and period_tick update on the following clk edge: 1-cycle latency.
- period_tick is high for exactly one clk cycle, on the same edge that count returns to 0.
- load_pending rises on the edge after load. It falls on the wrap edge that applies the values, or on the edge after load while disabled.
- rst mid-period clears all state immediately. The first tick after release starts counting from 0.

## Structure
- Shared GPIO header: default WIDTH and PRESCALER, and SELW derived via clog2.
- Sub-module gpio_tick_gen: tap mux, sel_q/tap_q registers and edge detect; output tick.
- Top level: pending/active double buffer, counter, comparator.

## Test plan
- sel=0, load period=3 duty=2, enable: tick every 2 clk; pwm_out high 4 clk then low 4 clk; period_tick every 8 clk; count runs 0,1,2,3.
- duty=0 -> pwm_out constant 0. period=3, duty=5 -> pwm_out constant 1. period=0 -> period_tick on every tick.
- Running period=3 duty=2; load period=7 duty=4 at count=1: current period finishes unchanged; at wrap load_pending falls and next period is 8 ticks with 4 high.
- Load coincident with wrap edge while another load is already pending: older values applied, newer held, load_pending stays 1 until the following wrap.
- prescaler_sel 0->3 while tap bits differ: no tick in the change cycle; subsequent ticks every 16 clk.
- rst pulse mid-period (count=2, pwm_out=1): all outputs 0 immediately. enable low with load_pending=1: values applied next edge, count=0, pwm_out=0.
